// File: rtl/mem_port_arbiter.sv
// N-port arbiter sharing one block-wide memory over a read/write/busywait handshake.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module mem_port_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [N_PORTS-1:0]           req_read,
    input  logic [N_PORTS-1:0]           req_write,
    input  logic [N_PORTS*ADDR_W-1:0]    req_address,
    input  logic [N_PORTS*BLOCK_W-1:0]   req_writedata,
    output logic [BLOCK_W-1:0]           req_readdata,
    output logic [N_PORTS-1:0]           req_busywait,
    output logic [$clog2(N_PORTS)-1:0]   grant_id,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [BLOCK_W-1:0]           mem_writedata,
    input  logic [BLOCK_W-1:0]           mem_readdata,
    input  logic                         mem_busywait
);
    localparam int unsigned ID_W = $clog2(N_PORTS);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic                issue_seen_q, issue_seen_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLOCK_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0]  rdata_q, rdata_d;

    logic [N_PORTS-1:0]  pending_c;
    logic [ID_W-1:0]     scan_c;
    logic [ID_W-1:0]     win_c;
    logic                win_valid_c;
    logic [ADDR_W-1:0]   win_addr_c;
    logic [BLOCK_W-1:0]  win_wdata_c;
    logic                win_rd_c;
    logic                win_wr_c;

    assign pending_c = req_read | req_write;

    // Search from rr_q upward with wrap; rr_q is pinned to 0 in fixed-priority builds.
    always_comb begin
        scan_c      = '0;
        win_c       = '0;
        win_valid_c = 1'b0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            scan_c = ID_W'((32'(rr_q) + k) % N_PORTS);
            if (!win_valid_c && pending_c[scan_c]) begin
                win_valid_c = 1'b1;
                win_c       = scan_c;
            end
        end
    end

    // Route the winner's request fields.
    always_comb begin
        win_addr_c  = '0;
        win_wdata_c = '0;
        win_rd_c    = 1'b0;
        win_wr_c    = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (ID_W'(i) == win_c) begin
                win_addr_c  = req_address[i*ADDR_W +: ADDR_W];
                win_wdata_c = req_writedata[i*BLOCK_W +: BLOCK_W];
                win_rd_c    = req_read[i];
                win_wr_c    = req_write[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        issue_seen_d = issue_seen_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_c) begin
                    state_d     = ST_BUSY;
                    grant_d     = win_c;
                    addr_d      = win_addr_c;
                    wdata_d     = win_wdata_c;
                    mem_write_d = win_wr_c;
                    mem_read_d  = win_rd_c & ~win_wr_c;
                end
            end
            ST_BUSY: begin
                // Memory may raise busywait a cycle late, so the first BUSY cycle never completes.
                if (!issue_seen_q) begin
                    issue_seen_d = 1'b1;
                end else if (!mem_busywait) begin
                    if (mem_read_q) begin
                        rdata_d = mem_readdata;
                    end
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    issue_seen_d = 1'b0;
                    state_d      = ST_DONE;
`ifdef MEM_ARB_FIXED_PRIO_EN
                    rr_d = '0;
`else
                    rr_d = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + ID_W'(1);
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            issue_seen_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            issue_seen_q <= issue_seen_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Stall every pending port except the owner during its single DONE cycle.
    always_comb begin
        req_busywait = pending_c;
        if (state_q == ST_DONE) begin
            req_busywait[grant_q] = 1'b0;
        end
    end

    assign req_readdata  = rdata_q;
    assign grant_id      = grant_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;

endmodule
